// File: rtl/display_snapshot_ctrl.sv
// -----------------------------------------------------------------------------
// display_snapshot_ctrl
//
// Frame-synchronous snapshot controller sitting between the matching engine and
// the VGA renderer. Market-state updates are accepted into a shadow register at
// any time. The shadow is copied to the renderer-facing registers only at the
// start of vertical blanking, once every FRAME_DIV frames, so a frame is never
// drawn from a half-updated book. Halt assertion bypasses the frame gating.
//
// Ports:
//   clk_25mhz    in   1  pixel clock, the only clock
//   rst          in   1  synchronous, active-high reset
//   h_cnt        in  10  horizontal pixel counter from VGA timing
//   v_cnt        in  10  vertical line counter from VGA timing
//   upd_valid    in   1  engine presents an update
//   upd_ready    out  1  update accepted this cycle (low only while committing)
//   upd_buy      in   8  best buy price
//   upd_sell     in   8  best sell price
//   upd_count    in   8  trade count
//   halt_in      in   1  engine halt request (level)
//   buy_price    out  8  committed buy price
//   sell_price   out  8  committed sell price
//   trade_count  out  8  committed trade count
//   spread       out  8  committed spread (0 when the book is crossed)
//   halt_signal  out  1  display halt flag
//   frame_tick   out  1  one-cycle pulse per commit opportunity
//   dropped_cnt  out  8  saturating count of updates overwritten before commit
// -----------------------------------------------------------------------------
module display_snapshot_ctrl #(
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned FRAME_DIV = 2
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       upd_valid,
    output logic       upd_ready,
    input  logic [7:0] upd_buy,
    input  logic [7:0] upd_sell,
    input  logic [7:0] upd_count,
    input  logic       halt_in,
    output logic [7:0] buy_price,
    output logic [7:0] sell_price,
    output logic [7:0] trade_count,
    output logic [7:0] spread,
    output logic       halt_signal,
    output logic       frame_tick,
    output logic [7:0] dropped_cnt
);

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Unsigned spread, clamped to zero when the book is crossed.
    function automatic logic [7:0] spread_clamp(input logic [7:0] sell, input logic [7:0] buy);
        return (sell >= buy) ? (sell - buy) : 8'd0;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : (cnt + 8'd1);
    endfunction

    state_t     state_q, state_d;
    logic       vs_cond, vs_cond_q, vs_cond_d, vs_start;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic       opp;
    logic       capture, commit_en;

    logic [7:0] sh_buy_q, sh_buy_d, sh_sell_q, sh_sell_d;
    logic [7:0] sh_count_q, sh_count_d, sh_spread_q, sh_spread_d;
    logic [7:0] buy_q, buy_d, sell_q, sell_d, count_q, count_d, spread_q, spread_d;
    logic [7:0] dropped_q, dropped_d;
    logic       halt_q, halt_d;
    logic       tick_q, tick_d;

    // Vblank start is the rising edge of the condition, so a stalled timing
    // generator sitting on the first blanking line still yields one pulse.
    assign vs_cond   = (v_cnt == 10'(V_ACTIVE)) && (h_cnt == 10'd0);
    assign vs_start  = vs_cond && !vs_cond_q;

    always_comb begin
        vs_cond_d = vs_cond;
        div_cnt_d = div_cnt_q;
        opp       = 1'b0;
        if (vs_start) begin
            if (div_cnt_q == DIV_LAST) begin
                opp       = 1'b1;
                div_cnt_d = 8'd0;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = PENDING;
            PENDING: if (opp)     state_d = COMMIT;
            COMMIT:               state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // FSM: outputs (functions of state only)
    always_comb begin
        upd_ready = (state_q != COMMIT);
        commit_en = (state_q == COMMIT);
    end

    assign capture = upd_valid && upd_ready;

    always_comb begin
        sh_buy_d    = sh_buy_q;
        sh_sell_d   = sh_sell_q;
        sh_count_d  = sh_count_q;
        sh_spread_d = sh_spread_q;
        buy_d       = buy_q;
        sell_d      = sell_q;
        count_d     = count_q;
        spread_d    = spread_q;
        dropped_d   = dropped_q;
        halt_d      = halt_q;
        tick_d      = opp;

        if (capture) begin
            sh_buy_d    = upd_buy;
            sh_sell_d   = upd_sell;
            sh_count_d  = upd_count;
            sh_spread_d = spread_clamp(upd_sell, upd_buy);
            // Shadow still held uncommitted data: that data is lost.
            if (state_q == PENDING) begin
                dropped_d = sat_inc(dropped_q);
            end
        end

        if (commit_en) begin
            buy_d    = sh_buy_q;
            sell_d   = sh_sell_q;
            count_d  = sh_count_q;
            spread_d = sh_spread_q;
        end

        // Halt sets immediately; release waits for a frame-aligned point so the
        // halt banner disappears together with a consistent snapshot.
        if (halt_in) begin
            halt_d = 1'b1;
        end else if (commit_en || (state_q == IDLE && opp)) begin
            halt_d = 1'b0;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            vs_cond_q   <= 1'b0;
            div_cnt_q   <= 8'd0;
            sh_buy_q    <= 8'd0;
            sh_sell_q   <= 8'd0;
            sh_count_q  <= 8'd0;
            sh_spread_q <= 8'd0;
            buy_q       <= 8'd0;
            sell_q      <= 8'd0;
            count_q     <= 8'd0;
            spread_q    <= 8'd0;
            dropped_q   <= 8'd0;
            halt_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            vs_cond_q   <= vs_cond_d;
            div_cnt_q   <= div_cnt_d;
            sh_buy_q    <= sh_buy_d;
            sh_sell_q   <= sh_sell_d;
            sh_count_q  <= sh_count_d;
            sh_spread_q <= sh_spread_d;
            buy_q       <= buy_d;
            sell_q      <= sell_d;
            count_q     <= count_d;
            spread_q    <= spread_d;
            dropped_q   <= dropped_d;
            halt_q      <= halt_d;
            tick_q      <= tick_d;
        end
    end

    assign buy_price   = buy_q;
    assign sell_price  = sell_q;
    assign trade_count = count_q;
    assign spread      = spread_q;
    assign dropped_cnt = dropped_q;
    assign halt_signal = halt_q;
    assign frame_tick  = tick_q;

endmodule

// File: tb/tb_display_snapshot_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for display_snapshot_ctrl. Two instances (FRAME_DIV = 1 and 2) share the
// same stimulus: a shortened VGA raster (4 pixels x 488 lines, vblank at 480),
// directed market updates in the first frames, then random updates, random halt
// toggles and random counter stalls. A frame-level reference model predicts all
// outputs every cycle.
// -----------------------------------------------------------------------------
module tb_display_snapshot_ctrl;

    localparam int H_TOT    = 4;
    localparam int V_TOT    = 488;
    localparam int V_ACT    = 480;
    localparam int N_FRAMES = 16;
    localparam logic [63:0] READY_ONLY = 64'h0000_0400_0000_0000;

    logic clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    logic       rst, upd_valid, halt_in;
    logic [9:0] h_cnt, v_cnt;
    logic [7:0] upd_buy, upd_sell, upd_count;

    logic       rdy1, halt1, tick1, rdy2, halt2, tick2;
    logic [7:0] buy1, sell1, cnt1, spr1, drop1;
    logic [7:0] buy2, sell2, cnt2, spr2, drop2;

    display_snapshot_ctrl #(.V_ACTIVE(480), .FRAME_DIV(1)) dut1 (
        .clk_25mhz(clk_25mhz), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .upd_valid(upd_valid), .upd_ready(rdy1), .upd_buy(upd_buy),
        .upd_sell(upd_sell), .upd_count(upd_count), .halt_in(halt_in),
        .buy_price(buy1), .sell_price(sell1), .trade_count(cnt1), .spread(spr1),
        .halt_signal(halt1), .frame_tick(tick1), .dropped_cnt(drop1)
    );

    display_snapshot_ctrl #(.V_ACTIVE(480), .FRAME_DIV(2)) dut2 (
        .clk_25mhz(clk_25mhz), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .upd_valid(upd_valid), .upd_ready(rdy2), .upd_buy(upd_buy),
        .upd_sell(upd_sell), .upd_count(upd_count), .halt_in(halt_in),
        .buy_price(buy2), .sell_price(sell2), .trade_count(cnt2), .spread(spr2),
        .halt_signal(halt2), .frame_tick(tick2), .dropped_cnt(drop2)
    );

    logic [63:0] act1, act2;
    assign act1 = {21'd0, rdy1, halt1, tick1, drop1, spr1, cnt1, sell1, buy1};
    assign act2 = {21'd0, rdy2, halt2, tick2, drop2, spr2, cnt2, sell2, buy2};

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference model: one entry per instance.
    logic       m_pend[2], m_commit[2], m_halt[2], m_tick[2], m_prev[2];
    int         m_vs[2], m_drop[2];
    logic [7:0] sh_b[2], sh_s[2], sh_c[2], o_b[2], o_s[2], o_c[2], o_sp[2];

    // Advances model instance i over one clock edge with the current inputs.
    task automatic model_step(input int i);
        logic cond, vs, opp, cap, go_commit;
        int   div;
        div = (i == 0) ? 1 : 2;
        if (rst) begin
            m_pend[i] = 0; m_commit[i] = 0; m_halt[i] = 0; m_tick[i] = 0; m_prev[i] = 0;
            m_vs[i] = 0; m_drop[i] = 0;
            sh_b[i] = 0; sh_s[i] = 0; sh_c[i] = 0;
            o_b[i] = 0; o_s[i] = 0; o_c[i] = 0; o_sp[i] = 0;
        end else begin
            cond = (v_cnt == 10'(V_ACT)) && (h_cnt == 10'd0);
            vs = cond && !m_prev[i];
            m_prev[i] = cond;
            opp = 1'b0;
            if (vs) begin
                opp = (m_vs[i] % div) == (div - 1);
                m_vs[i]++;
            end
            cap = upd_valid && !m_commit[i];
            if (m_commit[i]) begin
                o_b[i]  = sh_b[i];
                o_s[i]  = sh_s[i];
                o_c[i]  = sh_c[i];
                o_sp[i] = (sh_s[i] >= sh_b[i]) ? (sh_s[i] - sh_b[i]) : 8'd0;
            end
            if (halt_in) m_halt[i] = 1'b1;
            else if (m_commit[i] || (opp && !m_pend[i])) m_halt[i] = 1'b0;
            if (cap && m_pend[i] && m_drop[i] < 255) m_drop[i]++;
            if (cap) begin
                sh_b[i] = upd_buy; sh_s[i] = upd_sell; sh_c[i] = upd_count;
            end
            go_commit   = m_pend[i] && opp;
            m_pend[i]   = m_pend[i] ? !opp : cap;
            m_commit[i] = go_commit;
            m_tick[i]   = opp;
        end
    endtask

    function automatic logic [63:0] m_pack(input int i);
        return {21'd0, !m_commit[i], m_halt[i], m_tick[i], 8'(m_drop[i]),
                o_sp[i], o_c[i], o_s[i], o_b[i]};
    endfunction

    int   frame, vc, hc, k, ticks1, ticks2;
    logic pos_new, stall;

    function automatic logic at(input int f, input int v, input int h);
        return pos_new && (frame == f) && (vc == v) && (hc == h);
    endfunction

    task automatic set_upd(input logic [7:0] b, input logic [7:0] s, input logic [7:0] c);
        upd_valid = 1'b1; upd_buy = b; upd_sell = s; upd_count = c;
    endtask

    initial begin
        frame = 0; vc = 0; hc = 0; ticks1 = 0; ticks2 = 0; pos_new = 1'b0; stall = 1'b0;
        rst = 1'b1; upd_valid = 1'b0; upd_buy = '0; upd_sell = '0; upd_count = '0;
        halt_in = 1'b0; h_cnt = '0; v_cnt = '0;
        model_step(0);
        model_step(1);
        k = 0;
        while (frame < N_FRAMES) begin
            @(negedge clk_25mhz);
            k++;
            // Outputs now reflect the edge that sampled position (frame, vc, hc).
            check_val("dut1_outputs", act1, m_pack(0));
            check_val("dut2_outputs", act2, m_pack(1));
            if (tick1 === 1'b1) ticks1++;
            if (tick2 === 1'b1) ticks2++;

            if (k == 3) begin
                check_val("reset_state_d1", act1, READY_ONLY);
                check_val("reset_state_d2", act2, READY_ONLY);
            end
            if (at(1, 300, 0)) check_val("hold_until_vblank", 64'(buy1), 64'd0);
            if (at(1, V_ACT, 0)) begin
                check_val("commit_ready_low_d1", 64'(rdy1), 64'd0);
                check_val("commit_tick_d1", 64'(tick1), 64'd1);
                check_val("commit_not_yet_visible", 64'(buy1), 64'd0);
                check_val("commit_ready_low_d2", 64'(rdy2), 64'd0);
            end
            if (at(1, V_ACT, 1)) begin
                check_val("visible_c2_buy", 64'(buy1), 64'd100);
                check_val("ready_back_c2", 64'(rdy1), 64'd1);
                check_val("tick_one_cycle", 64'(tick1), 64'd0);
            end
            if (at(2, 0, 0)) begin
                check_val("f2_buy", 64'(buy1), 64'd100);
                check_val("f2_sell", 64'(sell1), 64'd110);
                check_val("f2_count", 64'(cnt1), 64'd3);
                check_val("f2_spread", 64'(spr1), 64'd10);
                check_val("f2_d2_buy", 64'(buy2), 64'd100);
                check_val("ticks_div1_f2", 64'(ticks1), 64'd2);
                check_val("ticks_div2_f2", 64'(ticks2), 64'd1);
            end
            if (at(3, 0, 0)) begin
                check_val("crossed_buy", 64'(buy1), 64'd120);
                check_val("crossed_sell", 64'(sell1), 64'd90);
                check_val("crossed_spread", 64'(spr1), 64'd0);
                check_val("div2_skip_buy", 64'(buy2), 64'd100);
            end
            if (at(4, 0, 0)) begin
                check_val("latest_wins_count", 64'(cnt1), 64'd9);
                check_val("latest_wins_spread", 64'(spr1), 64'd35);
                check_val("dropped_d1", 64'(drop1), 64'd3);
                check_val("dropped_d2", 64'(drop2), 64'd4);
                check_val("d2_count_f4", 64'(cnt2), 64'd9);
                check_val("ticks_div1_f4", 64'(ticks1), 64'd4);
                check_val("ticks_div2_f4", 64'(ticks2), 64'd2);
            end
            if (at(4, 100, 0)) check_val("halt_next_edge", 64'(halt1), 64'd1);
            if (at(4, 300, 0)) begin
                check_val("halt_held_d1", 64'(halt1), 64'd1);
                check_val("halt_held_d2", 64'(halt2), 64'd1);
            end
            if (at(5, 0, 0)) begin
                check_val("halt_clear_d1", 64'(halt1), 64'd0);
                check_val("halt_kept_d2", 64'(halt2), 64'd1);
            end
            if (at(6, 0, 0)) check_val("halt_clear_d2", 64'(halt2), 64'd0);
            if (at(7, 0, 0)) begin
                check_val("post_reset_d1", act1, READY_ONLY);
                check_val("post_reset_d2", act2, READY_ONLY);
            end
            if (at(9, 0, 0)) check_val("dropped_saturates", 64'(drop1), 64'd255);

            // Next raster position: held through reset, occasionally stalled later.
            pos_new = 1'b0;
            if (k == 3) begin
                pos_new = 1'b1;
            end else if (k > 3) begin
                stall = 1'b0;
                if (frame >= 7) begin
                    if (vc == V_ACT && hc == 0) stall = ($urandom_range(0, 1) == 0);
                    else                        stall = ($urandom_range(0, 15) == 0);
                end
                if (!stall) begin
                    pos_new = 1'b1;
                    hc++;
                    if (hc == H_TOT) begin
                        hc = 0;
                        vc++;
                        if (vc == V_TOT) begin
                            vc = 0;
                            frame++;
                        end
                    end
                end
            end

            rst = (k < 3) || at(6, 300, 0) || at(6, 300, 1);
            upd_valid = 1'b0;
            if (frame < 7) begin
                halt_in = at(4, 100, 0);
                if (at(1, 200, 0)) set_upd(8'd100, 8'd110, 8'd3);
                if (at(2, 200, 0)) set_upd(8'd120, 8'd90, 8'd7);
                if (at(3, 100, 0)) set_upd(8'd10, 8'd20, 8'd1);
                if (at(3, 200, 0)) set_upd(8'd11, 8'd21, 8'd2);
                if (at(3, 300, 0)) set_upd(8'd12, 8'd22, 8'd3);
                if (at(3, V_ACT, 0)) set_upd(8'd40, 8'd75, 8'd9);
                if (at(6, 200, 0)) set_upd(8'd33, 8'd44, 8'd5);
            end else begin
                if ($urandom_range(0, 1499) == 0) halt_in = !halt_in;
                if (($urandom_range(0, 499) == 0) || (frame == 8 && vc >= 10 && vc < 80))
                    set_upd(8'($urandom), 8'($urandom), 8'($urandom));
            end
            h_cnt = 10'(hc);
            v_cnt = 10'(vc);
            model_step(0);
            model_step(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_snapshot_ctrl.md
# display_snapshot_ctrl

Frame-synchronous snapshot controller between the matching engine and the VGA display renderer. Accepts market-state updates (best buy, best sell, trade count, halt) on a valid/ready handshake into a shadow register. It commits the shadow to the renderer-facing registers only at the start of vertical blanking, once every FRAME_DIV frames, so the picture never tears mid-frame. Also derives the spread, counts overwritten updates, and fast-paths halt assertion.

## Interface
Parameters:
- V_ACTIVE, 480: first blanking line; start of vblank is (v_cnt == V_ACTIVE && h_cnt == 0).
- FRAME_DIV, 2: commit every FRAME_DIV-th vblank start; legal range 1..255.

Ports:
- clk_25mhz  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- h_cnt  in  10  horizontal pixel counter from VGA timing.
- v_cnt  in  10  vertical line counter from VGA timing.
- upd_valid  in  1  engine presents an update.
- upd_ready  out  1  controller accepts the update this cycle.
- upd_buy  in  8  best buy price.
- upd_sell  in  8  best sell price.
- upd_count  in  8  trade count.
- halt_in  in  1  engine halt request, level.
- buy_price  out  8  committed buy price to renderer.
- sell_price  out  8  committed sell price.
- trade_count  out  8  committed trade count.
- spread  out  8  committed spread.
- halt_signal  out  1  display halt flag.
- frame_tick  out  1  one-cycle pulse per commit opportunity.
- dropped_cnt  out  8  saturating count of updates overwritten before commit.

## Operation
- Capture: when upd_valid && upd_ready, the shadow registers take upd_buy, upd_sell, upd_count, and shadow spread = (upd_sell >= upd_buy) ? upd_sell - upd_buy : 0.
  - Unsigned 8-bit arithmetic; the spread is clamped to 0 when the book is crossed.
  - Latest capture wins.
- upd_ready = (state != COMMIT). It is a combinational function of the state only.
- vs_start = rising edge of (v_cnt == V_ACTIVE && h_cnt == 0), using a registered copy of the condition. It fires for one cycle even if the counters stall.
- Frame divider div_cnt:
  - On vs_start with div_cnt == FRAME_DIV-1: commit opportunity (opp), and div_cnt returns to 0.
  - On any other vs_start: div_cnt increments.
- FSM states:
  - IDLE: no pending data. Capture goes to PENDING. An opp in IDLE is ignored and outputs hold.
  - PENDING: shadow holds uncommitted data. A further capture increments dropped_cnt (saturates at 255). An opp goes to COMMIT.
  - COMMIT: lasts one cycle. upd_ready = 0. Shadow copies to buy_price, sell_price, trade_count, spread. Returns to IDLE.
- Simultaneous capture and opp:
  - In PENDING: the capture is accepted and counted as dropped, the shadow takes the new data, and the new data is what COMMIT copies.
  - In IDLE: the capture goes to PENDING and waits for the next opp.
- Halt handling:
  - halt_in high sets halt_signal on the next edge, regardless of frame position.
  - halt_in low clears halt_signal only in a COMMIT cycle, or on an opp while in IDLE, and only if halt_in is still low at that point.
  - Captures continue while halted.
- frame_tick is registered and goes high the cycle after every opp.

## Timing
- Reset values:
  - All data outputs 0, halt_signal 0, frame_tick 0, dropped_cnt 0.
  - State IDLE, div_cnt 0, shadow 0, vs_start history 0.
  - upd_ready is 1 from the first cycle after reset.
- Reset mid-operation discards pending data. Committed outputs return to 0.
- Let cycle C be the cycle with an opp while in PENDING:
  - COMMIT occupies C+1 and frame_tick = 1 in C+1.
  - New outputs are visible from C+2.
- Capture-to-display latency is at least 2 cycles after the next opp. The worst case is FRAME_DIV frames plus 2 cycles.
- Halt assert-to-output latency is 1 cycle.

## Test plan
- Reset, then sweep one full frame with no updates -> all outputs 0, upd_ready = 1, and frame_tick pulses at the vblank start (FRAME_DIV = 1).
- Capture buy = 100, sell = 110, count = 3 mid-frame (v = 200) -> outputs unchanged until vblank. At v = 480/h = 0 cycle C, COMMIT in C+1 with upd_ready = 0. From C+2: buy_price 100, sell_price 110, trade_count 3, spread 10.
- Crossed book, buy = 120 and sell = 90 -> spread commits as 0.
- Three captures in one frame (counts 1, 2, 3) -> trade_count = 3 after commit and dropped_cnt = 2. A capture on the opp cycle itself commits its own data and increments dropped_cnt.
- FRAME_DIV = 2 with a capture every frame -> commits on every second vblank only, and frame_tick fires every second frame.
- halt_in pulse at v = 100 -> halt_signal = 1 one cycle later and held through the frame. It clears only at the next opp with halt_in low. Assert rst during PENDING -> the commit never occurs and outputs stay 0.
